// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-bus blocks: command codes,
// transmitter FSM encoding, status-word bit positions and a parity helper.
package uart_pkg;

  // Command field io_in7[1:0]
  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;
  localparam logic [1:0] CMD_SPARE  = 2'd3;

  // CONFIG payload that requests a soft reset of the transmit path
  localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

  // Transmitter frame FSM
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_t;

  // Status word bit positions
  localparam int STAT_BUSY     = 7;
  localparam int STAT_FULL     = 6;
  localparam int STAT_EMPTY    = 5;
  localparam int STAT_OVERFLOW = 4;
  localparam int STAT_TWO_STOP = 3;
  localparam int STAT_PAR_EN   = 2;
  localparam int STAT_PAR_ODD  = 1;
  localparam int STAT_TXD      = 0;

  // Even parity of the data bits, inverted for odd parity
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. DEPTH must be a power of two (>= 2)
// so the pointers wrap naturally. Push when full and pop when empty are
// ignored; a simultaneous push and pop are both honoured. flush empties the
// FIFO in one cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cmd.sv
// UART transmit stage driven by the 7-bit command bus.
// Bytes are assembled from two nibble writes, queued in uart_tx_fifo and sent
// 8N1/8N2 on io_txd with a bit period of DIV_BASE*(prediv+1) clocks.
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined;
// otherwise parEn/parOdd are stored and reported but have no effect on the line.
//
// Command handshake: io_cmdValid is an asynchronous level. It is synchronised
// by two flops and a third flop detects the rising edge; a command sampled high
// at edge N executes at edge N+2, reading io_in7 at that edge. The driver keeps
// io_in7 stable for at least three cycles after raising io_cmdValid. Held
// levels and falling edges do nothing.
module uart_tx_cmd
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_BASE   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_cmdValid,
  input  logic [6:0] io_in7,
  output logic       io_txd,
  output logic [7:0] io_out8,
  output logic       io_resetCommandStrobe
);

  localparam int CNT_W = $clog2(DIV_BASE * 32 + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  // Command synchroniser and edge detect
  logic cv_s1, cv_s2, cv_s3;
  logic exec;

  // Command decode
  logic [1:0] cmd;
  logic [4:0] payload;
  logic       soft_rst;

  // Configuration and command state
  logic [3:0] low_nib;
  logic [4:0] prediv;
  logic       two_stop;
  logic       par_en;
  logic       par_odd;
  logic       overflow;

  // FIFO interface
  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_wdata;
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;

  // Frame state, including values latched at pop
  tx_state_t        state;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] period_l;
  logic [2:0]       bit_idx;
  logic [7:0]       data_l;
  logic             two_stop_l;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             par_en_l;
  logic             par_bit_l;
`endif

  // Two-flop synchroniser plus edge-detect flop on the command strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_s1 <= 1'b0;
      cv_s2 <= 1'b0;
      cv_s3 <= 1'b0;
    end else begin
      cv_s1 <= io_cmdValid;
      cv_s2 <= cv_s1;
      cv_s3 <= cv_s2;
    end
  end

  assign exec       = cv_s2 && !cv_s3;
  assign cmd        = io_in7[1:0];
  assign payload    = io_in7[6:2];
  assign soft_rst   = exec && (cmd == CMD_CONFIG) && (payload == CMD_CONFIG_RESET);
  assign fifo_wdata = {payload[3:0], low_nib};
  assign fifo_push  = exec && (cmd == CMD_DATA) && payload[4] && !fifo_full;
  // A soft reset flushes the FIFO, so it must not also pop the head entry
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !soft_rst;
  assign bit_done   = (div_cnt == period_l - CNT_W'(1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (soft_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Command execution: nibble latch, overflow flag, configuration, prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_nib  <= '0;
      prediv   <= '0;
      two_stop <= 1'b0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      overflow <= 1'b0;
    end else if (exec) begin
      case (cmd)
        CMD_DATA: begin
          if (!payload[4]) begin
            low_nib <= payload[3:0];
          end else if (fifo_full) begin
            overflow <= 1'b1;
          end
        end
        CMD_CONFIG: begin
          if (payload == CMD_CONFIG_RESET) begin
            overflow <= 1'b0;
          end else if (payload[4:3] == 2'b00) begin
            two_stop <= payload[0];
            par_en   <= payload[1];
            par_odd  <= payload[2];
          end
        end
        CMD_PREDIV: begin
          prediv <= payload;
        end
        CMD_SPARE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // One-cycle pulse when a soft reset executes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_resetCommandStrobe <= 1'b0;
    end else begin
      io_resetCommandStrobe <= soft_rst;
    end
  end

  // Frame FSM: the line level is registered from the current state, so txd
  // follows the state by one clock and every bit lasts exactly one period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      io_txd     <= 1'b1;
      div_cnt    <= '0;
      period_l   <= CNT_W'(DIV_BASE);
      bit_idx    <= '0;
      data_l     <= '0;
      two_stop_l <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_l   <= 1'b0;
      par_bit_l  <= 1'b0;
`endif
    end else if (soft_rst) begin
      state   <= ST_IDLE;
      io_txd  <= 1'b1;
      div_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_START:  io_txd <= 1'b0;
        ST_DATA:   io_txd <= data_l[bit_idx];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: io_txd <= par_bit_l;
`endif
        default:   io_txd <= 1'b1;
      endcase

      if (state == ST_IDLE) begin
        div_cnt <= '0;
        bit_idx <= '0;
        if (fifo_pop) begin
          data_l     <= fifo_rdata;
          period_l   <= CNT_W'(DIV_BASE * (32'(prediv) + 32'd1));
          two_stop_l <= two_stop;
`ifdef UART_TX_PARITY_EN
          par_en_l   <= par_en;
          par_bit_l  <= parity_bit(fifo_rdata, par_odd);
`endif
          state      <= ST_START;
        end
      end else if (!bit_done) begin
        div_cnt <= div_cnt + CNT_W'(1);
      end else begin
        div_cnt <= '0;
        case (state)
          ST_START: state <= ST_DATA;
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= par_en_l ? ST_PARITY : ST_STOP1;
`else
              state   <= ST_STOP1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: state <= ST_STOP1;
`endif
          ST_STOP1: state <= two_stop_l ? ST_STOP2 : ST_IDLE;
          ST_STOP2: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered status word, one cycle behind the internal state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out8 <= 8'b0010_0001;
    end else begin
      io_out8[STAT_BUSY]     <= (state != ST_IDLE);
      io_out8[STAT_FULL]     <= fifo_full;
      io_out8[STAT_EMPTY]    <= (fifo_count == '0);
      io_out8[STAT_OVERFLOW] <= overflow;
      io_out8[STAT_TWO_STOP] <= two_stop;
      io_out8[STAT_PAR_EN]   <= par_en;
      io_out8[STAT_PAR_ODD]  <= par_odd;
      io_out8[STAT_TXD]      <= io_txd;
    end
  end

endmodule
